// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
// Segment patterns are logical (1 = lit), bit order {a,b,c,d,e,f,g}.
package seg7_pkg;

    localparam int SUBTICKS = 16;
    localparam int SEG_W    = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t HEX_TABLE [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79,
        7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F,
        7'h4E, 7'h3D, 7'h4F, 7'h47
    };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to logical segment pattern; a blanked digit lights nothing.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output seg_t       seg
);

    assign seg = blank ? '0 : HEX_TABLE[nibble];

endmodule

// File: rtl/seven_segment_mux.sv
// N-digit multiplexed seven-segment driver with PWM brightness,
// leading-zero blanking and frame-synchronous value updates.
module seven_segment_mux
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int DIV            = 3125,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit EN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk_50mhz,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic                  lz_blank,
    input  logic [3:0]            brightness,
    input  logic                  load,
    output logic                  pending,
    output logic                  frame_done,
    output logic [SEG_W-1:0]      seg,
    output logic                  seg_dp,
    output logic [N_DIGITS-1:0]   dsen
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [DIV_W-1:0]      div_cnt;
    logic [3:0]            sub;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            bright_lat;

    logic [4*N_DIGITS-1:0] pend_digits;
    logic [N_DIGITS-1:0]   pend_dp;
    logic                  pend_lz;
    logic                  pending_valid;

    logic [4*N_DIGITS-1:0] shadow_digits;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic                  shadow_lz;

    logic                  div_end;
    logic                  slot_end;
    logic                  frame_end;

    logic [N_DIGITS-1:0]   blank_mask;
    logic [3:0]            cur_nibble;
    logic                  cur_blank;
    logic                  cur_dp;
    logic                  en_lit;
    logic [N_DIGITS-1:0]   dsen_lit;
    seg_t                  seg_lit;

    assign div_end   = (div_cnt == DIV_W'(DIV - 1));
    assign slot_end  = div_end && (sub == 4'(SUBTICKS - 1));
    assign frame_end = slot_end && (idx == IDX_W'(N_DIGITS - 1));

    // A digit is blank when it and every digit to its left are zero.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank_mask = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            upper_zero    = upper_zero && (shadow_digits[4*i +: 4] == 4'h0);
            blank_mask[i] = shadow_lz && upper_zero && (i != 0);
        end
    end

    assign cur_nibble = shadow_digits[4*int'(idx) +: 4];
    assign cur_blank  = blank_mask[idx];
    assign cur_dp     = shadow_dp[idx];
    assign en_lit     = (sub != 4'd0) && (sub <= bright_lat);
    assign dsen_lit   = en_lit ? (N_DIGITS'(1) << idx) : '0;

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .blank  (cur_blank),
        .seg    (seg_lit)
    );

    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            div_cnt <= '0;
            sub     <= '0;
            idx     <= '0;
        end else if (div_end) begin
            div_cnt <= '0;
            sub     <= sub + 4'd1;
            if (slot_end)
                idx <= frame_end ? '0 : idx + IDX_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            pend_digits   <= '0;
            pend_dp       <= '0;
            pend_lz       <= 1'b0;
            pending_valid <= 1'b0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_lz     <= 1'b0;
        end else begin
            if (frame_end && pending_valid) begin
                shadow_digits <= pend_digits;
                shadow_dp     <= pend_dp;
                shadow_lz     <= pend_lz;
                pending_valid <= 1'b0;
            end
            // A load on the boundary wins; it is shown one frame later.
            if (load) begin
                pend_digits   <= digits;
                pend_dp       <= dp;
                pend_lz       <= lz_blank;
                pending_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            bright_lat <= '0;
            frame_done <= 1'b0;
            seg        <= {SEG_W{SEG_ACTIVE_LOW}};
            seg_dp     <= SEG_ACTIVE_LOW;
            dsen       <= {N_DIGITS{EN_ACTIVE_LOW}};
        end else begin
            if (sub == 4'd0)
                bright_lat <= brightness;
            frame_done <= frame_end;
            seg        <= seg_lit ^ {SEG_W{SEG_ACTIVE_LOW}};
            seg_dp     <= cur_dp ^ SEG_ACTIVE_LOW;
            dsen       <= dsen_lit ^ {N_DIGITS{EN_ACTIVE_LOW}};
        end
    end

    assign pending = pending_valid;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Randomised bench for seven_segment_mux against a cycle-count model.
module tb_seven_segment_mux;

    localparam int N     = 4;
    localparam int DIV   = 2;
    localparam int SLOT  = 16 * DIV;
    localparam int FRAME = SLOT * N;

    logic          clk_50mhz = 1'b0;
    logic          reset;
    logic [4*N-1:0] digits;
    logic [N-1:0]  dp;
    logic          lz_blank;
    logic [3:0]    brightness;
    logic          load;
    logic          pending;
    logic          frame_done;
    logic [6:0]    seg;
    logic          seg_dp;
    logic [N-1:0]  dsen;

    int checks = 0;
    int errors = 0;

    seven_segment_mux #(
        .N_DIGITS       (N),
        .DIV            (DIV),
        .SEG_ACTIVE_LOW (1'b1),
        .EN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk_50mhz  (clk_50mhz),
        .reset      (reset),
        .digits     (digits),
        .dp         (dp),
        .lz_blank   (lz_blank),
        .brightness (brightness),
        .load       (load),
        .pending    (pending),
        .frame_done (frame_done),
        .seg        (seg),
        .seg_dp     (seg_dp),
        .dsen       (dsen)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Standard hex glyphs, {a..g}, 1 = lit.
    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'b1111110;  1: return 7'b0110000;
            2: return 7'b1101101;  3: return 7'b1111001;
            4: return 7'b0110011;  5: return 7'b1011011;
            6: return 7'b1011111;  7: return 7'b1110000;
            8: return 7'b1111111;  9: return 7'b1111011;
            10: return 7'b1110111; 11: return 7'b0011111;
            12: return 7'b1001110; 13: return 7'b0111101;
            14: return 7'b1001111; default: return 7'b1000111;
        endcase
    endfunction

    // Model: position is pure arithmetic on cycles since reset.
    int           cyc = 0;
    bit           started = 0;
    logic [15:0]  m_sd, m_pd;
    logic [N-1:0] m_sdp, m_pdp;
    logic         m_slz, m_plz, m_pv;
    int           m_bright;
    logic [6:0]   e_seg;
    logic         e_dp, e_fd, e_pend;
    logic [N-1:0] e_dsen;

    always @(posedge clk_50mhz) begin
        int s, d, nib;
        bit blank;
        started = 1;
        if (!reset) begin
            cyc = 0; m_sd = 0; m_sdp = 0; m_slz = 0;
            m_pd = 0; m_pdp = 0; m_plz = 0; m_pv = 0;
            m_bright = 0;
            e_seg = 7'h7F; e_dp = 1; e_dsen = '1; e_fd = 0; e_pend = 0;
        end else begin
            s = (cyc / DIV) % 16;
            d = (cyc / SLOT) % N;
            if (s == 0) m_bright = brightness;
            nib = int'((m_sd >> (4 * d)) & 16'hF);
            blank = m_slz && d != 0 && ((m_sd >> (4 * d)) == 0);
            e_seg = ~(blank ? 7'h00 : glyph(nib));
            e_dp = ~m_sdp[d];
            e_dsen = (s >= 1 && s <= m_bright) ? ~(N'(1) << d) : '1;
            e_fd = (cyc % FRAME) == FRAME - 1;
            if (e_fd && m_pv) begin
                m_sd = m_pd; m_sdp = m_pdp; m_slz = m_plz; m_pv = 0;
            end
            if (load) begin
                m_pd = digits; m_pdp = dp; m_plz = lz_blank; m_pv = 1;
            end
            e_pend = m_pv;
            cyc++;
        end
    end

    always @(negedge clk_50mhz) begin
        if (started) begin
            check("seg", 32'(seg), 32'(e_seg));
            check("seg_dp", 32'(seg_dp), 32'(e_dp));
            check("dsen", 32'(dsen), 32'(e_dsen));
            check("pending", 32'(pending), 32'(e_pend));
            check("frame_done", 32'(frame_done), 32'(e_fd));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50mhz);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [N-1:0] p,
                           input logic lz);
        digits = v; dp = p; lz_blank = lz; load = 1;
        tick(1);
        load = 0;
    endtask

    // Stops at the negedge just before a boundary edge.
    task automatic wait_boundary();
        bit found = 0;
        for (int k = 0; k < FRAME + 4 && !found; k++) begin
            if (reset && (cyc % FRAME) == FRAME - 1) found = 1;
            else tick(1);
        end
        if (!found) check("boundary_wait", 0, 1);
    endtask

    initial begin
        reset = 0; digits = 0; dp = 0; lz_blank = 0;
        brightness = 15; load = 0;
        tick(3);
        check("rst_dsen", 32'(dsen), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_pend", 32'(pending), 0);
        reset = 1;
        tick(5);
        do_load(16'h4321, 4'b0010, 0);
        check("pend_after_load", 32'(pending), 1);
        tick(2 * FRAME);
        brightness = 0;
        tick(FRAME);
        brightness = 4;
        tick(FRAME);
        do_load(16'h0050, 4'b0100, 1);
        tick(2 * FRAME);
        do_load(16'h0000, 4'b0000, 1);
        tick(2 * FRAME);
        tick(FRAME / 3);
        do_load(16'hABCD, 4'b1001, 0);
        tick(FRAME + 10);
        do_load(16'h1111, 4'b0001, 0);
        wait_boundary();
        do_load(16'h2222, 4'b0010, 0);
        tick(2 * FRAME + 5);
        tick(SLOT + 7);
        reset = 0;
        tick(1);
        check("midrst_pend", 32'(pending), 0);
        check("midrst_dsen", 32'(dsen), 32'hF);
        reset = 1;
        tick(FRAME);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                digits = 16'($urandom);
                if ($urandom_range(0, 2) == 0) digits = digits & 16'h00FF;
                dp = N'($urandom);
                lz_blank = 1'($urandom);
                load = 1;
            end else begin
                load = 0;
            end
            if ($urandom_range(0, 49) == 0) brightness = 4'($urandom);
            reset = ($urandom_range(0, 799) != 0);
            tick(1);
        end
        reset = 1; load = 0;
        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
